// File: rtl/mult_div_unit.sv
// Multi-cycle multiply/divide unit with the HI/LO register pair for the E stage.
// A busy window of MULT_CYCLES/DIV_CYCLES models latency; the result commits as the window closes.
module mult_div_unit #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  MDop,
    input  logic        HIwrite,
    input  logic        LOwrite,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        MD_yes,
    output logic        busy,
    output logic        stall_md,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

    typedef enum logic {
        S_IDLE,
        S_BUSY
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [1:0]         op_q, op_d;
    logic [31:0]        a_q, a_d;
    logic [31:0]        b_q, b_d;
    logic [31:0]        hi_q, hi_d;
    logic [31:0]        lo_q, lo_d;

    logic               is_signed;
    logic [63:0]        a_ext, b_ext, product;
    logic               a_neg, b_neg;
    logic [31:0]        abs_a, abs_b, q_mag, r_mag, quot, rem;

    // Signed divide works on magnitudes so 0x80000000 / -1 yields 0x80000000 without overflow.
    always_comb begin
        is_signed = op_q[0];
        a_ext     = is_signed ? {{32{a_q[31]}}, a_q} : {32'd0, a_q};
        b_ext     = is_signed ? {{32{b_q[31]}}, b_q} : {32'd0, b_q};
        product   = a_ext * b_ext;

        a_neg = is_signed & a_q[31];
        b_neg = is_signed & b_q[31];
        abs_a = a_neg ? (~a_q + 32'd1) : a_q;
        abs_b = b_neg ? (~b_q + 32'd1) : b_q;
        q_mag = (abs_b == 32'd0) ? 32'd0 : abs_a / abs_b;
        r_mag = (abs_b == 32'd0) ? 32'd0 : abs_a % abs_b;
        quot  = (a_neg ^ b_neg) ? (~q_mag + 32'd1) : q_mag;
        rem   = a_neg ? (~r_mag + 32'd1) : r_mag;
    end

    // NOTE: every next-state signal is defaulted to its current value first, so no path
    // through the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        hi_d    = hi_q;
        lo_d    = lo_q;

        case (state_q)
            S_IDLE: begin
                if (start && !MDop[2]) begin
                    state_d = S_BUSY;
                    op_d    = MDop[1:0];
                    a_d     = A;
                    b_d     = B;
                    cnt_d   = MDop[1] ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
                end else begin
                    if (HIwrite) hi_d = A;
                    if (LOwrite) lo_d = A;
                end
            end
            S_BUSY: begin
                if (cnt_q == CNT_W'(1)) begin
                    state_d = S_IDLE;
                    if (!op_q[1]) begin
                        {hi_d, lo_d} = product;
                    end else if (b_q != 32'd0) begin
                        hi_d = rem;
                        lo_d = quot;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // the pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign busy     = (state_q == S_BUSY);
    assign stall_md = MD_yes & (start | busy);
    assign HI       = hi_q;
    assign LO       = lo_q;

endmodule
